// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM command path
// between one write and one read requester.
module sdram_port_arbiter #(
  parameter int ASIZE   = 23,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             INIT_REQ,
  input  logic             REF_REQ,
  input  logic             CMD_ACK,
  input  logic             WR_REQ,
  input  logic [ASIZE-1:0] WR_ADDR,
  output logic             WR_ACK,
  input  logic             RD_REQ,
  input  logic [ASIZE-1:0] RD_ADDR,
  output logic             RD_ACK,
  input  logic             ERR_CLR,
  output logic [2:0]       CMD,
  output logic [ASIZE-1:0] ADDR,
  output logic             BUSY,
  output logic             TIMEOUT_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  localparam int GAPL = (GAP < 1) ? 1 : GAP;
  localparam int GW   = $clog2(GAPL + 1);

  localparam logic [2:0] C_NOP = 3'b000;
  localparam logic [2:0] C_RD  = 3'b001;
  localparam logic [2:0] C_WR  = 3'b010;

  localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAPL);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  state_t           state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic             wr_ack_q, wr_ack_d;
  logic             rd_ack_q, rd_ack_d;
  logic             busy_q;
  logic             err_q, err_d;
  logic             last_wr_q, last_wr_d;
  logic [15:0]      to_q, to_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic hold;
  logic idle_go;
  logic pick_rd;
  logic abort;
  logic acked;
  logic tmo;
  logic gap_done;

  // Shared decisions for both FSM combinational processes
  always_comb begin
    hold     = INIT_REQ | REF_REQ;
    idle_go  = (state_q == S_IDLE) && !hold
               && (WR_REQ || RD_REQ);
    pick_rd  = RD_REQ && (!WR_REQ || last_wr_q);
    abort    = (state_q == S_ISSUE) && INIT_REQ;
    acked    = (state_q == S_ISSUE) && !INIT_REQ
               && CMD_ACK;
    tmo      = (state_q == S_ISSUE) && !INIT_REQ
               && !CMD_ACK && (to_q == TO_LAST);
    gap_done = (state_q == S_GAP) && (gap_q == GAP_ONE);
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      idle_go:       state_d = S_ISSUE;
      abort:         state_d = S_IDLE;
      acked || tmo:  state_d = S_GAP;
      gap_done:      state_d = S_IDLE;
      default:       state_d = state_q;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wr_ack_d  = 1'b0;
    rd_ack_d  = 1'b0;
    last_wr_d = last_wr_q;
    to_d      = to_q;
    gap_d     = gap_q;
    err_d     = tmo ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
    unique case (state_q)
      S_IDLE: begin
        if (idle_go) begin
          cmd_d     = pick_rd ? C_RD : C_WR;
          addr_d    = pick_rd ? RD_ADDR : WR_ADDR;
          last_wr_d = !pick_rd;
          to_d      = '0;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          cmd_d = C_NOP;
        end else if (acked) begin
          cmd_d    = C_NOP;
          wr_ack_d = (cmd_q == C_WR);
          rd_ack_d = (cmd_q == C_RD);
          gap_d    = GAP_LOAD;
        end else if (tmo) begin
          cmd_d = C_NOP;
          gap_d = GAP_LOAD;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      S_GAP: begin
        if (!gap_done) begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: begin
        cmd_d = C_NOP;
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd_q     <= C_NOP;
      addr_q    <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b1;
      to_q      <= '0;
      gap_q     <= '0;
    end else begin
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      busy_q    <= (state_d != S_IDLE);
      err_q     <= err_d;
      last_wr_q <= last_wr_d;
      to_q      <= to_d;
      gap_q     <= gap_d;
    end
  end

  assign CMD         = cmd_q;
  assign ADDR        = addr_q;
  assign WR_ACK      = wr_ack_q;
  assign RD_ACK      = rd_ack_q;
  assign BUSY        = busy_q;
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter
// (GAP=4, TIMEOUT=8).
module tb_sdram_port_arbiter;

  localparam int AW = 23;

  logic          CLK;
  logic          RESET_N;
  logic          INIT_REQ;
  logic          REF_REQ;
  logic          CMD_ACK;
  logic          WR_REQ;
  logic [AW-1:0] WR_ADDR;
  logic          WR_ACK;
  logic          RD_REQ;
  logic [AW-1:0] RD_ADDR;
  logic          RD_ACK;
  logic          ERR_CLR;
  logic [2:0]    CMD;
  logic [AW-1:0] ADDR;
  logic          BUSY;
  logic          TIMEOUT_ERR;

  int checks;
  int failures;

  sdram_port_arbiter #(
    .ASIZE(AW),
    .GAP(4),
    .TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .INIT_REQ(INIT_REQ),
    .REF_REQ(REF_REQ),
    .CMD_ACK(CMD_ACK),
    .WR_REQ(WR_REQ),
    .WR_ADDR(WR_ADDR),
    .WR_ACK(WR_ACK),
    .RD_REQ(RD_REQ),
    .RD_ADDR(RD_ADDR),
    .RD_ACK(RD_ACK),
    .ERR_CLR(ERR_CLR),
    .CMD(CMD),
    .ADDR(ADDR),
    .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET_N  = 1'b1;
    INIT_REQ = 1'b0;
    REF_REQ  = 1'b0;
    CMD_ACK  = 1'b0;
    WR_REQ   = 1'b0;
    RD_REQ   = 1'b0;
    WR_ADDR  = '0;
    RD_ADDR  = '0;
    ERR_CLR  = 1'b0;
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_cmd", 32'(CMD), 32'h0);
    chk("rst_addr", 32'(ADDR), 32'h0);
    chk("rst_acks", 32'({WR_ACK, RD_ACK}), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_err", 32'(TIMEOUT_ERR), 32'h0);
    step(2);
    RESET_N = 1'b1;

    // Init holds off a pending write
    INIT_REQ = 1'b1;
    WR_REQ   = 1'b1;
    WR_ADDR  = 23'h0ABCDE;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("init_hold_cmd", 32'(CMD), 32'h0);
    end
    INIT_REQ = 1'b0;
    step();
    chk("init_grant_cmd", 32'(CMD), 32'h2);
    chk("init_grant_addr", 32'(ADDR), 32'h0ABCDE);
    chk("init_grant_busy", 32'(BUSY), 32'h1);
    step(2);
    CMD_ACK = 1'b1;
    step();
    CMD_ACK = 1'b0;
    WR_REQ  = 1'b0;
    chk("w1_ack", 32'(WR_ACK), 32'h1);
    chk("w1_cmd_nop", 32'(CMD), 32'h0);
    step();
    chk("w1_ack_pulse", 32'(WR_ACK), 32'h0);
    step(2);
    chk("w1_gap_busy", 32'(BUSY), 32'h1);
    step();
    chk("w1_idle_busy", 32'(BUSY), 32'h0);

    // Both requesting: strict alternation, 8-cycle spacing
    WR_ADDR = 23'h111111;
    RD_ADDR = 23'h222222;
    WR_REQ  = 1'b1;
    RD_REQ  = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rr_cmd", 32'(CMD),
          (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_addr", 32'(ADDR),
          (i % 2 == 0) ? 32'h222222 : 32'h111111);
      step(2);
      CMD_ACK = 1'b1;
      step();
      CMD_ACK = 1'b0;
      chk("rr_acks", 32'({WR_ACK, RD_ACK}),
          (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i == 3) begin
        WR_REQ = 1'b0;
        RD_REQ = 1'b0;
      end
      step();
      chk("rr_ack_pulse", 32'({WR_ACK, RD_ACK}), 32'h0);
      step(3);
      chk("rr_gap_cmd", 32'(CMD), 32'h0);
      step();
    end
    chk("rr_end_cmd", 32'(CMD), 32'h0);
    chk("rr_end_busy", 32'(BUSY), 32'h0);

    // Address latched at grant
    RD_ADDR = 23'h012345;
    RD_REQ  = 1'b1;
    step();
    chk("lat_cmd", 32'(CMD), 32'h1);
    chk("lat_addr0", 32'(ADDR), 32'h012345);
    RD_ADDR = '0;
    step();
    chk("lat_addr1", 32'(ADDR), 32'h012345);
    step();
    CMD_ACK = 1'b1;
    step();
    CMD_ACK = 1'b0;
    RD_REQ  = 1'b0;
    chk("lat_ack", 32'(RD_ACK), 32'h1);
    chk("lat_addr2", 32'(ADDR), 32'h012345);
    step(4);
    CMD_ACK = 1'b1;
    step();
    CMD_ACK = 1'b0;
    chk("stray_ack", 32'({WR_ACK, RD_ACK, BUSY}), 32'h0);

    // Refresh during ISSUE; next grant waits for it
    WR_ADDR = 23'h000333;
    WR_REQ  = 1'b1;
    step();
    chk("ref_cmd", 32'(CMD), 32'h2);
    REF_REQ = 1'b1;
    RD_ADDR = 23'h000444;
    RD_REQ  = 1'b1;
    step(2);
    CMD_ACK = 1'b1;
    step();
    CMD_ACK = 1'b0;
    chk("ref_wr_ack", 32'(WR_ACK), 32'h1);
    chk("ref_cmd_nop", 32'(CMD), 32'h0);
    step(4);
    step(5);
    chk("ref_hold_cmd", 32'(CMD), 32'h0);
    chk("ref_hold_busy", 32'(BUSY), 32'h0);
    REF_REQ = 1'b0;
    step();
    chk("ref_next_cmd", 32'(CMD), 32'h1);
    chk("ref_next_addr", 32'(ADDR), 32'h000444);
    step(2);
    CMD_ACK = 1'b1;
    step();
    CMD_ACK = 1'b0;
    WR_REQ  = 1'b0;
    RD_REQ  = 1'b0;
    chk("ref_rd_ack", 32'(RD_ACK), 32'h1);
    step(4);

    // Timeout after 8 ISSUE cycles without ack
    WR_ADDR = 23'h000555;
    WR_REQ  = 1'b1;
    step();
    chk("to_cmd", 32'(CMD), 32'h2);
    WR_REQ = 1'b0;
    step(7);
    chk("to_still_cmd", 32'(CMD), 32'h2);
    chk("to_no_err_yet", 32'(TIMEOUT_ERR), 32'h0);
    step();
    chk("to_cmd_nop", 32'(CMD), 32'h0);
    chk("to_err", 32'(TIMEOUT_ERR), 32'h1);
    chk("to_no_ack", 32'({WR_ACK, RD_ACK}), 32'h0);
    step();
    chk("to_no_ack2", 32'({WR_ACK, RD_ACK}), 32'h0);
    chk("to_gap_busy", 32'(BUSY), 32'h1);
    chk("to_err_sticky", 32'(TIMEOUT_ERR), 32'h1);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    chk("to_err_clr", 32'(TIMEOUT_ERR), 32'h0);
    step(2);
    chk("to_idle_busy", 32'(BUSY), 32'h0);

    // Reset during ISSUE; first tie after reset goes to read
    RD_ADDR = 23'h0AAAAA;
    WR_ADDR = 23'h055555;
    RD_REQ  = 1'b1;
    WR_REQ  = 1'b1;
    step();
    chk("mid_cmd", 32'(CMD), 32'h1);
    step();
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_cmd", 32'(CMD), 32'h0);
    chk("mid_rst_addr", 32'(ADDR), 32'h0);
    chk("mid_rst_busy", 32'(BUSY), 32'h0);
    step(2);
    RESET_N = 1'b1;
    step();
    chk("post_rst_cmd", 32'(CMD), 32'h1);
    chk("post_rst_addr", 32'(ADDR), 32'h0AAAAA);
    chk("post_rst_noack", 32'({WR_ACK, RD_ACK}), 32'h0);
    step(2);
    CMD_ACK = 1'b1;
    step();
    CMD_ACK = 1'b0;
    RD_REQ  = 1'b0;
    WR_REQ  = 1'b0;
    chk("post_rst_ack", 32'({WR_ACK, RD_ACK}), 32'h1);
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
